// File: rtl/audio_fx_pkg.sv
// Shared audio effect definitions: FSM encodings, sample limits and saturation helper.
package audio_fx_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_CLIP    = 3'd3;
  localparam logic [2:0] ST_PRESENT = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    FETCH   = ST_FETCH,
    CAPTURE = ST_CAPTURE,
    CLIP    = ST_CLIP,
    PRESENT = ST_PRESENT,
    HOLD    = ST_HOLD
  } clip_state_t;

  localparam logic signed [DATA_WIDTH-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [DATA_WIDTH-1:0] SAMPLE_MIN = 16'sh8000;

  // Clamp a signed value into the range of a w-bit two's complement number (w <= 31).
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/clip_core.sv
// Combinational hard clipper: symmetric threshold compare, optional make-up shift, saturation.
module clip_core
  import audio_fx_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int shift      = 0
) (
  input  logic signed [data_width-1:0] sample,
  input  logic        [data_width-2:0] threshold,
  output logic        [data_width-1:0] wet,
  output logic                         clipped
);

  logic signed [data_width:0] x_ext_s;
  logic signed [data_width:0] t_pos_s;
  logic signed [data_width:0] t_neg_s;
  logic signed [data_width:0] lim_s;

  // One extra bit keeps -T representable for any threshold value.
  always_comb begin
    x_ext_s = {sample[data_width-1], sample};
    t_pos_s = {2'b00, threshold};
    t_neg_s = -t_pos_s;
    if (x_ext_s > t_pos_s) begin
      lim_s   = t_pos_s;
      clipped = 1'b1;
    end else if (x_ext_s < t_neg_s) begin
      lim_s   = t_neg_s;
      clipped = 1'b1;
    end else begin
      lim_s   = x_ext_s;
      clipped = 1'b0;
    end
  end

  // With shift = 0 the saturation is a no-op and wet equals the clipped value.
  always_comb begin
    wet = data_width'(sat_signed(32'(lim_s) <<< shift, data_width));
  end

endmodule

// File: rtl/effect_clipper.sv
// Hard-clipping effect stage between the ADC sample FIFO and the mixer.
// Optional make-up gain on the wet path is enabled by defining CLIPPER_MAKEUP_GAIN_EN.
module effect_clipper
  import audio_fx_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int cnt_width  = 16,
  parameter int gain_shift = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic [data_width-1:0] i_fifo_data,
  input  logic [data_width-2:0] i_threshold,
  input  logic                  i_read_ready,
  input  logic                  i_read_done,
  output logic                  o_dv,
  output logic [data_width-1:0] o_data_sw0,
  output logic [data_width-1:0] o_data_sw1,
  output logic [cnt_width-1:0]  o_clip_cnt
);

`ifdef CLIPPER_MAKEUP_GAIN_EN
  localparam bit GAIN_EN = 1'b1;
`else
  localparam bit GAIN_EN = 1'b0;
`endif
  localparam int GAIN_SHIFT_EFF = GAIN_EN ? gain_shift : 0;

  clip_state_t                  state_r;
  logic signed [data_width-1:0] dry_r;
  logic        [data_width-1:0] wet_r;
  logic        [data_width-1:0] wet_s;
  logic                         clipped_s;

  clip_core #(
    .data_width (data_width),
    .shift      (GAIN_SHIFT_EFF)
  ) u_clip_core (
    .sample    (dry_r),
    .threshold (i_threshold),
    .wet       (wet_s),
    .clipped   (clipped_s)
  );

  // The pop strobe is only high during the IDLE cycle that commits to a read.
  always_comb begin
    if (reset) begin
      o_fifo_rd = 1'b0;
    end else if ((state_r == IDLE) && !i_fifo_empty) begin
      o_fifo_rd = 1'b1;
    end else begin
      o_fifo_rd = 1'b0;
    end
  end

  // Handshake FSM, sample pipeline, output registers and saturating clip counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      dry_r      <= {data_width{1'b0}};
      wet_r      <= {data_width{1'b0}};
      o_dv       <= 1'b0;
      o_data_sw0 <= {data_width{1'b0}};
      o_data_sw1 <= {data_width{1'b0}};
      o_clip_cnt <= {cnt_width{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (!i_fifo_empty) begin
            state_r <= FETCH;
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: begin
          state_r <= CAPTURE;
        end
        CAPTURE: begin
          dry_r   <= i_fifo_data;
          state_r <= CLIP;
        end
        CLIP: begin
          wet_r <= wet_s;
          if (clipped_s && (o_clip_cnt != {cnt_width{1'b1}})) begin
            o_clip_cnt <= o_clip_cnt + cnt_width'(1);
          end
          state_r <= PRESENT;
        end
        PRESENT: begin
          if (i_read_ready) begin
            o_data_sw0 <= dry_r;
            o_data_sw1 <= wet_r;
            o_dv       <= 1'b1;
            state_r    <= HOLD;
          end else begin
            state_r <= PRESENT;
          end
        end
        HOLD: begin
          if (i_read_done) begin
            o_dv    <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          o_dv    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_effect_clipper.sv
// Directed self-checking bench for effect_clipper (default and 4-bit counter instances).
`ifdef CLIPPER_MAKEUP_GAIN_EN
`define WET(plain, gain) (gain)
`else
`define WET(plain, gain) (plain)
`endif

module tb_effect_clipper;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_fifo_empty;
  logic        o_fifo_rd, o_fifo_rd4;
  logic [15:0] i_fifo_data;
  logic [14:0] i_threshold;
  logic        i_read_ready;
  logic        i_read_done;
  logic        o_dv, o_dv4;
  logic [15:0] o_data_sw0, o_data_sw1, sw0_4, sw1_4;
  logic [15:0] o_clip_cnt;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;

  always #5 clk = ~clk;

  effect_clipper dut (
    .clk(clk), .reset(reset), .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd),
    .i_fifo_data(i_fifo_data), .i_threshold(i_threshold), .i_read_ready(i_read_ready),
    .i_read_done(i_read_done), .o_dv(o_dv), .o_data_sw0(o_data_sw0),
    .o_data_sw1(o_data_sw1), .o_clip_cnt(o_clip_cnt)
  );

  effect_clipper #(.cnt_width(4)) dut4 (
    .clk(clk), .reset(reset), .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd4),
    .i_fifo_data(i_fifo_data), .i_threshold(i_threshold), .i_read_ready(i_read_ready),
    .i_read_done(i_read_done), .o_dv(o_dv4), .o_data_sw0(sw0_4),
    .o_data_sw1(sw1_4), .o_clip_cnt(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Count read strobes away from the active edge.
  always @(negedge clk) begin
    if (o_fifo_rd === 1'b1) rd_cnt++;
  end

  task automatic xfer(input string tag, input logic [15:0] x, input logic [14:0] t,
                      input logic [15:0] e1, input int ecnt, input int ecnt4);
    int rd0;
    int cyc;
    @(posedge clk); #2;
    i_threshold = t; i_fifo_data = x; i_fifo_empty = 1'b0; rd0 = rd_cnt;
    @(posedge clk); #2;
    i_fifo_empty = 1'b1;
    cyc = 1;
    while (o_dv !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 32'd5);
    check({tag, " rd pulses"}, rd_cnt - rd0, 32'd1);
    check({tag, " sw0"}, {16'h0, o_data_sw0}, {16'h0, x});
    check({tag, " sw1"}, {16'h0, o_data_sw1}, {16'h0, e1});
    check({tag, " cnt"}, {16'h0, o_clip_cnt}, ecnt);
    check({tag, " cnt4"}, {28'h0, cnt4}, ecnt4);
    @(posedge clk); #2; i_read_done = 1'b1;
    @(posedge clk); #2; i_read_done = 1'b0;
    check({tag, " dv low after done"}, {31'h0, o_dv}, 32'd0);
  endtask

  initial begin
    int rd0;
    logic [15:0] x;
    reset = 1'b1; i_fifo_empty = 1'b1; i_fifo_data = 16'h0; i_threshold = 15'h0;
    i_read_ready = 1'b1; i_read_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dv", {31'h0, o_dv}, 32'd0);
    check("reset sw0", {16'h0, o_data_sw0}, 32'd0);
    check("reset sw1", {16'h0, o_data_sw1}, 32'd0);
    check("reset cnt", {16'h0, o_clip_cnt}, 32'd0);
    check("reset rd", {31'h0, o_fifo_rd}, 32'd0);
    @(posedge clk); #2; reset = 1'b0;

    xfer("pass 0800", 16'h0800, 15'h1000, `WET(16'h0800, 16'h1000), 0, 0);
    xfer("clip 7fff", 16'h7FFF, 15'h1000, `WET(16'h1000, 16'h2000), 1, 1);
    xfer("clip 8000", 16'h8000, 15'h1000, `WET(16'hF000, 16'hE000), 2, 2);

    // Mixer not ready: result must wait in PRESENT without new pops.
    i_read_ready = 1'b0;
    @(posedge clk); #2;
    i_threshold = 15'h1000; i_fifo_data = 16'hF000; i_fifo_empty = 1'b0; rd0 = rd_cnt;
    @(posedge clk); #2; i_fifo_empty = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("stall dv", {31'h0, o_dv}, 32'd0);
    check("stall rd pulses", rd_cnt - rd0, 32'd1);
    @(posedge clk); #2; i_read_ready = 1'b1;
    @(posedge clk); #1;
    check("ready dv", {31'h0, o_dv}, 32'd1);
    check("ready sw0", {16'h0, o_data_sw0}, 32'h0000F000);
    check("ready sw1", {16'h0, o_data_sw1}, {16'h0, `WET(16'hF000, 16'hE000)});
    check("ready cnt", {16'h0, o_clip_cnt}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2; i_read_ready = ~i_read_ready;
      check("hold dv", {31'h0, o_dv}, 32'd1);
      check("hold sw0", {16'h0, o_data_sw0}, 32'h0000F000);
    end
    i_read_ready = 1'b1; i_read_done = 1'b1;
    @(posedge clk); #1;
    check("done wins dv", {31'h0, o_dv}, 32'd0);
    #1; i_read_done = 1'b0;
    @(posedge clk); #1;
    check("idle ignores ready", {31'h0, o_dv}, 32'd0);
    check("sw0 kept", {16'h0, o_data_sw0}, 32'h0000F000);

    xfer("t0 nonzero", 16'h0001, 15'h0000, 16'h0000, 3, 3);
    xfer("t0 zero", 16'h0000, 15'h0000, 16'h0000, 3, 3);
    xfer("tmax min", 16'h8000, 15'h7FFF, `WET(16'h8001, 16'h8000), 4, 4);
    xfer("tmax max", 16'h7FFF, 15'h7FFF, `WET(16'h7FFF, 16'h7FFF), 4, 4);
    xfer("gain 6000", 16'h6000, 15'h5000, `WET(16'h5000, 16'h7FFF), 5, 5);

    for (int i = 0; i < 16; i++) begin
      x = 16'(i + 1);
      xfer("sat loop", x, 15'h0000, 16'h0000, 6 + i, (6 + i > 15) ? 15 : 6 + i);
    end
    check("final cnt", {16'h0, o_clip_cnt}, 32'd21);
    check("final cnt4", {28'h0, cnt4}, 32'd15);

    // Asynchronous reset while the result is held for the mixer.
    @(posedge clk); #2;
    i_threshold = 15'h1000; i_fifo_data = 16'h0555; i_fifo_empty = 1'b0;
    @(posedge clk); #2; i_fifo_empty = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("pre-reset dv", {31'h0, o_dv}, 32'd1);
    i_fifo_empty = 1'b0;
    reset = 1'b1;
    #1;
    check("async dv", {31'h0, o_dv}, 32'd0);
    check("async sw0", {16'h0, o_data_sw0}, 32'd0);
    check("async sw1", {16'h0, o_data_sw1}, 32'd0);
    check("async cnt", {16'h0, o_clip_cnt}, 32'd0);
    check("async rd", {31'h0, o_fifo_rd}, 32'd0);
    rd0 = rd_cnt;
    repeat (3) @(posedge clk);
    #2;
    check("no pop in reset", rd_cnt - rd0, 32'd0);
    i_fifo_empty = 1'b1; reset = 1'b0;
    #1;
    check("rd after release", {31'h0, o_fifo_rd}, 32'd0);
    xfer("post reset", 16'h0123, 15'h1000, `WET(16'h0123, 16'h0246), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
